// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: logical (1 = lit) patterns for the BCD
// digits and the nibble-to-pattern decode used by the scan driver.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Non-BCD nibbles (10..15) decode dark rather than to hex glyphs.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] nibble);
        logic [6:0] pat;
        case (nibble)
            4'd0:    pat = SEG_0;
            4'd1:    pat = SEG_1;
            4'd2:    pat = SEG_2;
            4'd3:    pat = SEG_3;
            4'd4:    pat = SEG_4;
            4'd5:    pat = SEG_5;
            4'd6:    pat = SEG_6;
            4'd7:    pat = SEG_7;
            4'd8:    pat = SEG_8;
            4'd9:    pat = SEG_9;
            default: pat = SEG_BLANK;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/seg7_digit_enc.sv
// Combinational decode of one BCD nibble to a logical segment pattern,
// forced dark when the digit is blanked.
module seg7_digit_enc
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        if (blank) begin
            seg = SEG_BLANK;
        end else begin
            seg = bcd_to_seg(nibble);
        end
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit seven-segment driver: shadow-latched BCD word,
// one digit per PRESCALE-cycle slot, optional leading-zero blanking.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int PRESCALE   = 50000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   digits_in,
    input  logic                      blank_lz,
    input  logic                      enable,
    output logic [6:0]                SEG,
    output logic [NUM_DIGITS-1:0]     AN,
    output logic                      frame_done
);

    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PW = $clog2(PRESCALE);

    localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_DIGITS - 1);
    localparam logic [IW-1:0] IDX_ONE   = IW'(1);
    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);
    localparam logic [PW-1:0] PRESC_ONE = PW'(1);

    localparam logic [6:0] SEG_OFF =
        (ACTIVE_LOW != 0) ? ~SEG_BLANK : SEG_BLANK;
    localparam logic [NUM_DIGITS-1:0] AN_OFF =
        (ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic [PW-1:0]           presc_q, presc_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic                    frame_done_q, frame_done_d;
    logic [6:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;

    logic [NUM_DIGITS-1:0]   zero_from;
    logic                    all_zero;
    logic [3:0]              cur_nib;
    logic                    cur_blank;
    logic [NUM_DIGITS-1:0]   onehot;
    logic [6:0]              enc_seg;

    // Shadow capture and slot/digit scan counters; both counters freeze while disabled.
    always_comb begin
        shadow_d     = shadow_q;
        presc_d      = presc_q;
        idx_d        = idx_q;
        frame_done_d = 1'b0;
        if (load) begin
            shadow_d = digits_in;
        end else begin
            shadow_d = shadow_q;
        end
        if (enable) begin
            if (presc_q == PRESC_MAX) begin
                presc_d = '0;
                if (idx_q == IDX_MAX) begin
                    idx_d        = '0;
                    frame_done_d = 1'b1;
                end else begin
                    idx_d = idx_q + IDX_ONE;
                end
            end else begin
                presc_d = presc_q + PRESC_ONE;
            end
        end else begin
            presc_d = presc_q;
            idx_d   = idx_q;
        end
    end

    // zero_from[i] is set when shadow digits i..top are all zero; it drives
    // leading-zero blanking of the currently selected digit (never digit 0).
    always_comb begin
        all_zero  = 1'b1;
        zero_from = '0;
        cur_nib   = 4'h0;
        cur_blank = 1'b0;
        onehot    = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            all_zero     = all_zero & (shadow_q[4*i +: 4] == 4'h0);
            zero_from[i] = all_zero;
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                cur_nib   = shadow_q[4*i +: 4];
                cur_blank = blank_lz & zero_from[i] & (i != 0);
                onehot[i] = 1'b1;
            end else begin
                onehot[i] = 1'b0;
            end
        end
    end

    seg7_digit_enc u_digit_enc (
        .nibble (cur_nib),
        .blank  (cur_blank),
        .seg    (enc_seg)
    );

    // Output stage: polarity applied here so SEG/AN leave the block straight from flops.
    always_comb begin
        seg_d = SEG_OFF;
        an_d  = AN_OFF;
        if (enable) begin
            if (ACTIVE_LOW != 0) begin
                seg_d = ~enc_seg;
                an_d  = ~onehot;
            end else begin
                seg_d = enc_seg;
                an_d  = onehot;
            end
        end else begin
            seg_d = SEG_OFF;
            an_d  = AN_OFF;
        end
    end

    // State and output registers; reset overrides any coincident load.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_q     <= '0;
            presc_q      <= '0;
            idx_q        <= '0;
            frame_done_q <= 1'b0;
            seg_q        <= SEG_OFF;
            an_q         <= AN_OFF;
        end else begin
            shadow_q     <= shadow_d;
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            frame_done_q <= frame_done_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
        end
    end

    assign SEG        = seg_q;
    assign AN         = an_q;
    assign frame_done = frame_done_q;

endmodule
